// File: rtl/dbg_bridge_pkg.sv
// Shared constants for the debug bridge: opcodes, reply codes and FSM state encoding.
package dbg_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_HALT  = 8'h48;
    localparam logic [7:0] OP_GO    = 8'h47;

    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARGS     = 3'd1;
    localparam logic [2:0] ST_BUS_REQ  = 3'd2;
    localparam logic [2:0] ST_BUS_ACC  = 3'd3;
    localparam logic [2:0] ST_BUS_DONE = 3'd4;
    localparam logic [2:0] ST_REPLY    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_ARGS     = ST_ARGS,
        S_BUS_REQ  = ST_BUS_REQ,
        S_BUS_ACC  = ST_BUS_ACC,
        S_BUS_DONE = ST_BUS_DONE,
        S_REPLY    = ST_REPLY
    } state_t;

    // Argument bytes following an opcode; zero means the command replies at once.
    function automatic logic [2:0] arg_count(input logic [7:0] op);
        case (op)
            OP_WRITE: arg_count = 3'd4;
            OP_READ:  arg_count = 3'd2;
            default:  arg_count = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dbg_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// pulses expired on the cycle the count reaches CYCLES-1.
module dbg_timeout #(
    parameter int unsigned CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/dbg_bridge.sv
// Debug bridge responder: parses byte commands from the UART receive stream,
// runs single 16-bit bus transfers as a second initiator and returns reply bytes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for an opcode byte
// ARGS     | collecting address/data bytes, idle timeout running
// BUS_REQ  | bus requested, waiting for grant
// BUS_ACC  | one-cycle address (and write) phase
// BUS_DONE | read data sampled, request released afterwards
// REPLY    | presenting reply bytes to the transmitter
module dbg_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    output logic [15:0] o_bus_addr,
    output logic [15:0] o_bus_wdata,
    output logic        o_bus_we,
    input  logic [15:0] i_bus_rdata,
    output logic        o_cpu_hold
);

    state_t      state;
    state_t      next_state;
    logic [7:0]  opcode;
    logic [31:0] args;
    logic [2:0]  byte_cnt;
    logic [2:0]  arg_len;
    logic [15:0] rdata;
    logic        reply_idx;
    logic        hold;

    logic        expired;
    logic        is_write;
    logic        is_read;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [7:0]  reply_byte;
    logic        reply_last;

    logic        bus_req;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic        tx_valid;
    logic [7:0]  tx_data;

    dbg_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (i_clk),
        .reset   (i_reset),
        .clear   ((state != S_ARGS) || i_rx_valid),
        .enable  (state == S_ARGS),
        .expired (expired)
    );

    assign is_write  = (opcode == OP_WRITE);
    assign is_read   = (opcode == OP_READ);
    // Write fills all four bytes (addr then data); read leaves its address in the low half.
    assign cmd_addr  = is_write ? args[31:16] : args[15:0];
    assign cmd_wdata = is_write ? args[15:0] : 16'h0000;

    always_comb begin
        reply_byte = NAK_BYTE;
        reply_last = 1'b1;
        case (opcode)
            OP_READ: begin
                reply_byte = reply_idx ? rdata[7:0] : rdata[15:8];
                reply_last = reply_idx;
            end
            OP_WRITE, OP_HALT, OP_GO: reply_byte = ACK_BYTE;
            default: reply_byte = NAK_BYTE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        bus_req    = 1'b0;
        bus_addr   = 16'h0000;
        bus_wdata  = 16'h0000;
        bus_we     = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    next_state = (arg_count(i_rx_data) != 3'd0) ? S_ARGS : S_REPLY;
                end
            end
            S_ARGS: begin
                if (i_rx_valid) begin
                    if (byte_cnt + 3'd1 == arg_len) begin
                        next_state = S_BUS_REQ;
                    end
                end else if (expired) begin
                    next_state = S_IDLE;
                end
            end
            S_BUS_REQ: begin
                bus_req = 1'b1;
                if (i_bus_gnt) begin
                    next_state = S_BUS_ACC;
                end
            end
            S_BUS_ACC: begin
                bus_req    = 1'b1;
                bus_addr   = cmd_addr;
                bus_wdata  = cmd_wdata;
                bus_we     = is_write;
                next_state = S_BUS_DONE;
            end
            S_BUS_DONE: begin
                bus_req    = 1'b1;
                bus_addr   = cmd_addr;
                bus_wdata  = cmd_wdata;
                next_state = S_REPLY;
            end
            S_REPLY: begin
                tx_valid = 1'b1;
                tx_data  = reply_byte;
                if (i_tx_ready && reply_last) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            opcode    <= 8'h00;
            args      <= 32'h0;
            byte_cnt  <= 3'd0;
            arg_len   <= 3'd0;
            rdata     <= 16'h0000;
            reply_idx <= 1'b0;
            hold      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        opcode    <= i_rx_data;
                        arg_len   <= arg_count(i_rx_data);
                        args      <= 32'h0;
                        byte_cnt  <= 3'd0;
                        reply_idx <= 1'b0;
                        if (i_rx_data == OP_HALT) hold <= 1'b1;
                        if (i_rx_data == OP_GO)   hold <= 1'b0;
                    end
                end
                S_ARGS: begin
                    if (i_rx_valid) begin
                        args     <= {args[23:0], i_rx_data};
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                S_BUS_DONE: begin
                    if (is_read) rdata <= i_bus_rdata;
                end
                S_REPLY: begin
                    if (i_tx_ready) reply_idx <= !reply_last;
                end
                default: ;
            endcase
        end
    end

    // Reset also masks the control outputs combinationally so they fall in the reset cycle itself.
    assign o_bus_req   = bus_req & ~i_reset;
    assign o_bus_we    = bus_we & ~i_reset;
    assign o_tx_valid  = tx_valid & ~i_reset;
    assign o_cpu_hold  = hold & ~i_reset;
    assign o_bus_addr  = bus_addr;
    assign o_bus_wdata = bus_wdata;
    assign o_tx_data   = tx_data;

endmodule
